// File: rtl/aes_pkg.sv
// Shared AES constants, loader state encoding and byte-lane helpers.
package aes_pkg;

   localparam int AES_BLOCK_W     = 128;
   localparam int AES_BLOCK_BYTES = 16;
   localparam int BYTE_W          = 8;

   // Pad byte value for a whole extra PKCS#7 block.
   localparam logic [7:0] PKCS7_FULL_PAD = 8'h10;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_HOLD,
      ST_PAD
   } loader_state_t;

   // MSB bit index of AES byte i (byte 0 sits at bits [127:120]).
   function automatic int byte_msb(input int i);
      return AES_BLOCK_W - 1 - BYTE_W * i;
   endfunction

endpackage

// File: rtl/aes_pad_gen.sv
// Pads the unfilled tail of a partial block: zeros, or PKCS#7 byte count.
module aes_pad_gen
   import aes_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [AES_BLOCK_W-1:0] blk_in,
   input  logic [3:0]             cnt,
   input  logic                   pkcs7,
   output logic [AES_BLOCK_W-1:0] blk_out
);

   localparam int B = DATA_W / 8;

   int         fill;
   logic [7:0] pad_val;

   // Bytes past the last written word get the pad value.
   always_comb begin
      fill    = B * (int'(cnt) + 1);
      pad_val = pkcs7 ? 8'(AES_BLOCK_BYTES - fill) : 8'h00;
      blk_out = blk_in;
      for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
         if (i >= fill) blk_out[byte_msb(i) -: 8] = pad_val;
      end
   end

endmodule

// File: rtl/aes_block_loader.sv
// Assembles DATA_W-bit plaintext words into padded 128-bit AES blocks.
// Optional PKCS#7 padding and trailing pad block: define AES_LOADER_PKCS7_EN.
module aes_block_loader
   import aes_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [AES_BLOCK_W-1:0] blk_data,
   output logic                   blk_valid,
   input  logic                   blk_ready,
   output logic                   blk_last,
   output logic [31:0]            blk_count
);

   localparam int N = AES_BLOCK_W / DATA_W;

   loader_state_t          state, n_state;
   logic [3:0]             cnt, n_cnt;
   logic [AES_BLOCK_W-1:0] asm_q, n_asm, asm_wr, padded;
   logic                   hold_last, n_hold_last;
   logic                   pad_pend, n_pad_pend;
   logic [AES_BLOCK_W-1:0] n_blk_data;
   logic                   n_blk_valid, n_blk_last;
   logic [31:0]            n_blk_count;
   logic                   accept, hs, slot_free, done, last_flag, pend, pkcs7;

`ifdef AES_LOADER_PKCS7_EN
   assign pkcs7 = 1'b1;
`else
   assign pkcs7 = 1'b0;
`endif

   assign in_ready  = rst_n && (state == ST_FILL);
   assign accept    = in_valid && in_ready;
   assign hs        = blk_valid && blk_ready;
   assign slot_free = !blk_valid || blk_ready;
   assign done      = (cnt == 4'(N - 1)) || in_last;

   // Current word merged into the assembly register at its beat position.
   always_comb begin
      asm_wr = asm_q;
      asm_wr[AES_BLOCK_W - 1 - int'(cnt) * DATA_W -: DATA_W] = in_data;
   end

   aes_pad_gen #(.DATA_W(DATA_W)) u_pad (
      .blk_in  (asm_wr),
      .cnt     (cnt),
      .pkcs7   (pkcs7),
      .blk_out (padded)
   );

   // A last word landing exactly on a block boundary defers blk_last to
   // an extra all-pad block when PKCS#7 is enabled.
   always_comb begin
`ifdef AES_LOADER_PKCS7_EN
      pend      = in_last && (cnt == 4'(N - 1));
      last_flag = in_last && !pend;
`else
      pend      = 1'b0;
      last_flag = in_last;
`endif
   end

   // Next-state, assembly and output-slot update.
   always_comb begin
      n_state     = state;
      n_cnt       = cnt;
      n_asm       = asm_q;
      n_hold_last = hold_last;
      n_pad_pend  = pad_pend;
      n_blk_data  = blk_data;
      n_blk_valid = blk_valid;
      n_blk_last  = blk_last;
      n_blk_count = blk_count;
      if (hs) begin
         n_blk_valid = 1'b0;
         n_blk_count = blk_count + 32'd1;
      end
      case (state)
         ST_FILL: begin
            if (accept) begin
               if (!done) begin
                  n_asm = asm_wr;
                  n_cnt = cnt + 4'd1;
               end else begin
                  n_cnt = 4'd0;
                  if (slot_free) begin
                     n_blk_data  = padded;
                     n_blk_valid = 1'b1;
                     n_blk_last  = last_flag;
                     n_state     = pend ? ST_PAD : ST_FILL;
                  end else begin
                     n_asm       = padded;
                     n_hold_last = last_flag;
                     n_pad_pend  = pend;
                     n_state     = ST_HOLD;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (hs) begin
               n_blk_data  = asm_q;
               n_blk_valid = 1'b1;
               n_blk_last  = hold_last;
               n_state     = pad_pend ? ST_PAD : ST_FILL;
            end
         end
`ifdef AES_LOADER_PKCS7_EN
         ST_PAD: begin
            if (slot_free) begin
               n_blk_data  = {AES_BLOCK_BYTES{PKCS7_FULL_PAD}};
               n_blk_valid = 1'b1;
               n_blk_last  = 1'b1;
               n_state     = ST_FILL;
            end
         end
`endif
         default: n_state = ST_FILL;
      endcase
   end

   // State and datapath registers; reset discards any partial block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_FILL;
         cnt       <= 4'd0;
         asm_q     <= '0;
         hold_last <= 1'b0;
         pad_pend  <= 1'b0;
         blk_data  <= '0;
         blk_valid <= 1'b0;
         blk_last  <= 1'b0;
         blk_count <= 32'd0;
      end else begin
         state     <= n_state;
         cnt       <= n_cnt;
         asm_q     <= n_asm;
         hold_last <= n_hold_last;
         pad_pend  <= n_pad_pend;
         blk_data  <= n_blk_data;
         blk_valid <= n_blk_valid;
         blk_last  <= n_blk_last;
         blk_count <= n_blk_count;
      end
   end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream feeder for the AES cipher core.
- Accepts plaintext as a stream of DATA_W-bit words over a valid/ready handshake and assembles them into 128-bit blocks.
- Presents each block on a 128-bit valid/ready output that drives the cipher's input_bytes.
- Pads a short final block; a 1-block output slot plus the assembly register give double buffering, so the cipher never waits on word assembly.

Parameters:
- DATA_W, 32, input word width in bits; legal values 8, 16, 32, 64; N = 128/DATA_W beats per block, B = DATA_W/8 bytes per beat.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_W  plaintext word; first word goes to the most-significant end
- in_valid  input  1  in_data valid
- in_last  input  1  qualifies in_data as the final word of the message
- in_ready  output  1  loader accepts a word this cycle
- blk_data  output  128  assembled block; bits [127:120] are AES byte 0
- blk_valid  output  1  blk_data valid
- blk_ready  input  1  downstream accepts the block
- blk_last  output  1  block is the final block of the message
- blk_count  output  32  number of blocks handed off since reset; wraps at 2^32

Behaviour:
- Reset (rst_n low, async):
  - blk_valid=0, blk_last=0, blk_data=0, blk_count=0, beat counter cnt=0, state=FILL.
  - in_ready is forced 0 while rst_n is low.
  - A partial block or held block is discarded; nothing resumes after reset.
- State FILL:
  - in_ready=1. A word is accepted when in_valid && in_ready.
  - The accepted word is written to assembly bits [127-cnt*DATA_W -: DATA_W].
  - If cnt != N-1 and in_last=0: cnt increments.
  - If cnt == N-1 or in_last=1, the block is complete. Unfilled bytes are padded (see feature; default zero) and cnt returns to 0.
- Completed-block handoff:
  - If the output slot is empty, or is being consumed this same cycle (blk_valid && blk_ready), the block loads into the output slot at the next edge and the state stays FILL.
  - Otherwise the block stays in the assembly register and state goes to HOLD.
- State HOLD:
  - in_ready=0.
  - On blk_valid && blk_ready, the held block moves into the output slot at that edge and the state returns to FILL.
- Output slot timing and rules:
  - Latency: final word accepted at edge t gives blk_valid=1 after edge t (visible in cycle t+1).
  - blk_data and blk_last hold stable while blk_valid && !blk_ready.
  - blk_valid clears after the handshake edge unless a new block loads at that same edge.
  - Sustained throughput is one block per N cycles when N >= 2. For DATA_W=8..64 no bubbles are inserted while blk_ready=1.
- blk_last: set on the block completed by an in_last word (without the feature).
- blk_count: increments on every blk_valid && blk_ready.
- in_last on a word with cnt==0: a block containing one word plus padding is produced.
- in_valid is ignored while in_ready=0, so in_data/in_last may change freely.

Optional Feature:
- Macro: AES_LOADER_PKCS7_EN.
- Defined:
  - Pad bytes are filled with value P = 16 - B*(cnt+1), the number of pad bytes.
  - If in_last arrives with cnt == N-1 (exact block boundary), the data block is emitted with blk_last=0. Then state PAD (in_ready=0) loads an extra block of sixteen 0x10 bytes with blk_last=1 as soon as the output slot is free, and returns to FILL.
- Undefined: pad bytes are 0x00, state PAD does not exist, and no extra block is ever generated.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128 and AES_BLOCK_BYTES=16.
  - Loader state encoding: FILL, HOLD, PAD.
  - Byte-lane helper constants.
- Sub-module aes_pad_gen (combinational): takes the partial block, cnt and the padding mode, and returns the padded 128-bit block.

Test Plan:
1. Basic block (DATA_W=32, blk_ready=1):
   - Stimulus: words 0x00112233, 0x44556677, 0x8899aabb, 0xccddeeff with in_last=0.
   - Response: blk_data=0x00112233445566778899aabbccddeeff one cycle after the 4th word, blk_last=0, blk_count=1.
2. Backpressure:
   - Stimulus: blk_ready=0, stream 8 words.
   - Response: block 1 held in the output slot, block 2 in assembly, state HOLD, in_ready=0 after word 8. Raising blk_ready delivers both in order with identical data; blk_count=2.
3. Short final block:
   - Stimulus: 0xdeadbeef, 0x01020304 with in_last on the 2nd word.
   - Response: blk_data=0xdeadbeef010203040000000000000000, blk_last=1. With AES_LOADER_PKCS7_EN the low 8 bytes are 0x08 each.
4. Exact-boundary last word, AES_LOADER_PKCS7_EN defined:
   - Stimulus: 4 words, in_last on the 4th.
   - Response: data block with blk_last=0, then a block of sixteen 0x10 bytes with blk_last=1; in_ready=0 until the pad block loads. Macro undefined: single block with blk_last=1.
5. Reset mid-block:
   - Stimulus: 2 words, assert rst_n low for 1 cycle, then 4 fresh words.
   - Response: blk_valid=0 and blk_count=0 during reset; the next block contains only the 4 fresh words.
6. Simultaneous handoff:
   - Stimulus: complete a block in the same cycle the output handshake occurs.
   - Response: the new block appears next cycle with blk_valid continuously 1 and no HOLD entry.
